// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and latency constants for the fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_HOLD} fetch_state_t;
  localparam int LAT_W = 3;
  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 4;
endpackage

// File: rtl/fetch_lat_cnt.sv
// fetch_lat_cnt: loadable down-counter that flags its last cycle (count == 1).
module fetch_lat_cnt
  import fetch_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             dec,
  input  logic [LAT_W-1:0] load_val,
  output logic             last
);
  logic [LAT_W-1:0] count;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (load) count <= load_val;
    else if (dec && count != '0) count <= count - LAT_W'(1);
  assign last = count == LAT_W'(1);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences PC/ROM for instruction fetch and hands words to decode via valid/ready.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              rom_cen,
  output logic              rom_ren,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);
  if (ROM_LAT < ROM_LAT_MIN || ROM_LAT > ROM_LAT_MAX) begin : g_bad_lat
    $error("fetch_ctrl: ROM_LAT out of range");
  end
  fetch_state_t state, state_nxt;
  logic last, handshake, capture;
  logic [ADDR_W-1:0] req_pc;
  assign handshake = state == F_HOLD && instr_ready;
  assign capture = state == F_WAIT && last && !branch_valid;
  assign pc_load_addr = branch_target;
  fetch_lat_cnt u_lat (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (state == F_REQ),
    .dec      (state == F_WAIT),
    .load_val (LAT_W'(ROM_LAT)),
    .last     (last)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= F_IDLE;
    else state <= state_nxt;
  // A branch restarts fetch unless a halting handshake retires the stage in the same cycle.
  always_comb begin
    state_nxt = state;
    pc_load = reset_n && branch_valid;
    pc_inc = state == F_REQ && !branch_valid;
    rom_cen = state == F_REQ;
    rom_ren = state == F_REQ;
    case (state)
      F_IDLE: state_nxt = start && !halt ? F_REQ : F_IDLE;
      F_REQ: state_nxt = F_WAIT;
      F_WAIT: state_nxt = last ? F_HOLD : F_WAIT;
      F_HOLD: state_nxt = handshake ? (halt ? F_IDLE : F_REQ) : F_HOLD;
      default: state_nxt = F_IDLE;
    endcase
    if (branch_valid && state != F_IDLE && !(handshake && halt)) state_nxt = F_REQ;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      req_pc <= '0;
      instr <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (state == F_REQ) req_pc <= pc_cur;
      if (capture) begin
        instr <= rom_data;
        instr_pc <= req_pc;
        instr_valid <= 1'b1;
      end else if (handshake || branch_valid) instr_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl against a PC model and a 2-cycle ROM model.
module tb_fetch_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LAT = 2;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic branch_valid = 1'b0;
  logic instr_ready = 1'b1;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] pc_cur, pc_load_addr, instr_pc;
  logic pc_inc, pc_load, rom_cen, rom_ren, instr_valid;
  logic [DW-1:0] rom_data, instr;
  logic [AW-1:0] rd1 = '0;
  logic [AW-1:0] rd2 = '0;
  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .halt(halt),
    .branch_valid(branch_valid), .branch_target(branch_target), .pc_cur(pc_cur),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .rom_cen(rom_cen), .rom_ren(rom_ren), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return a * 16'd3 + 16'h1234;
  endfunction

  always @(posedge clock or negedge reset_n)
    if (!reset_n) pc_cur <= '0;
    else if (pc_load) pc_cur <= pc_load_addr;
    else if (pc_inc) pc_cur <= pc_cur + 16'd1;

  always @(posedge clock) begin
    if (rom_cen && rom_ren) rd1 <= pc_cur;
    rd2 <= rd1;
  end
  assign rom_data = rom_word(rd2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_outs(input string tag);
    check({tag, "_cen"}, 32'(rom_cen), 0);
    check({tag, "_ren"}, 32'(rom_ren), 0);
    check({tag, "_inc"}, 32'(pc_inc), 0);
    check({tag, "_ld"}, 32'(pc_load), 0);
    check({tag, "_vld"}, 32'(instr_valid), 0);
  endtask

  initial begin
    step();
    step();
    idle_outs("rst");
    check("rst_instr", 32'(instr), 0);
    check("rst_ipc", 32'(instr_pc), 0);
    reset_n = 1'b1;
    step();
    idle_outs("idle");
    // first fetch from 0x0000, zero-wait decode
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("c0_inc", 32'(pc_inc), 1);
    check("c0_ren", 32'(rom_ren), 1);
    check("c0_cen", 32'(rom_cen), 1);
    check("c0_ld", 32'(pc_load), 0);
    step();
    check("c1_vld", 32'(instr_valid), 0);
    check("c1_pc", 32'(pc_cur), 1);
    check("c1_ren", 32'(rom_ren), 0);
    step();
    check("c2_vld", 32'(instr_valid), 0);
    step();
    check("c3_vld", 32'(instr_valid), 1);
    check("c3_instr", 32'(instr), 32'(rom_word(16'h0000)));
    check("c3_ipc", 32'(instr_pc), 0);
    step();
    check("c4_ren", 32'(rom_ren), 1);
    check("c4_inc", 32'(pc_inc), 1);
    check("c4_vld", 32'(instr_valid), 0);
    // back-pressure on the second instruction
    instr_ready = 1'b0;
    step();
    step();
    step();
    check("bp_vld", 32'(instr_valid), 1);
    check("bp_instr", 32'(instr), 32'(rom_word(16'h0001)));
    check("bp_ipc", 32'(instr_pc), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_vld", 32'(instr_valid), 1);
      check("bp_hold_instr", 32'(instr), 32'(rom_word(16'h0001)));
      check("bp_hold_ipc", 32'(instr_pc), 1);
      check("bp_hold_ren", 32'(rom_ren), 0);
      check("bp_hold_inc", 32'(pc_inc), 0);
    end
    step();
    instr_ready = 1'b1;
    check("bp_last_vld", 32'(instr_valid), 1);
    step();
    check("bp_res_ren", 32'(rom_ren), 1);
    check("bp_res_inc", 32'(pc_inc), 1);
    check("bp_res_vld", 32'(instr_valid), 0);
    check("bp_res_pc", 32'(pc_cur), 2);
    // branch to 0x0040 during F_WAIT
    step();
    branch_valid = 1'b1;
    branch_target = 16'h0040;
    #1;
    check("bw_ld", 32'(pc_load), 1);
    check("bw_inc", 32'(pc_inc), 0);
    check("bw_addr", 32'(pc_load_addr), 32'h40);
    step();
    branch_valid = 1'b0;
    #1;
    check("bw_req_ren", 32'(rom_ren), 1);
    check("bw_req_pc", 32'(pc_cur), 32'h40);
    check("bw_req_vld", 32'(instr_valid), 0);
    step();
    check("bw_w1_vld", 32'(instr_valid), 0);
    step();
    check("bw_w2_vld", 32'(instr_valid), 0);
    step();
    check("bw_vld", 32'(instr_valid), 1);
    check("bw_ipc", 32'(instr_pc), 32'h40);
    check("bw_instr", 32'(instr), 32'(rom_word(16'h0040)));
    // branch and handshake in the same F_HOLD cycle
    branch_valid = 1'b1;
    branch_target = 16'h0080;
    #1;
    check("bh_ld", 32'(pc_load), 1);
    check("bh_inc", 32'(pc_inc), 0);
    step();
    branch_valid = 1'b0;
    #1;
    check("bh_req_vld", 32'(instr_valid), 0);
    check("bh_req_ren", 32'(rom_ren), 1);
    check("bh_req_pc", 32'(pc_cur), 32'h80);
    step();
    check("bh_w1_vld", 32'(instr_valid), 0);
    step();
    check("bh_w2_vld", 32'(instr_valid), 0);
    step();
    check("bh_vld", 32'(instr_valid), 1);
    check("bh_ipc", 32'(instr_pc), 32'h80);
    check("bh_instr", 32'(instr), 32'(rom_word(16'h0080)));
    // halt raised in F_WAIT
    step();
    check("h_req_ren", 32'(rom_ren), 1);
    step();
    halt = 1'b1;
    step();
    check("h_w2_vld", 32'(instr_valid), 0);
    step();
    check("h_vld", 32'(instr_valid), 1);
    check("h_ipc", 32'(instr_pc), 32'h81);
    step();
    idle_outs("h_idle");
    start = 1'b1;
    step();
    idle_outs("h_blk1");
    step();
    idle_outs("h_blk2");
    halt = 1'b0;
    step();
    start = 1'b0;
    #1;
    check("h_rst_ren", 32'(rom_ren), 1);
    check("h_rst_pc", 32'(pc_cur), 32'h82);
    // asynchronous reset mid-F_WAIT
    step();
    reset_n = 1'b0;
    #1;
    idle_outs("ar_wait");
    step();
    reset_n = 1'b1;
    step();
    idle_outs("ar_after");
    check("ar_instr", 32'(instr), 0);
    // asynchronous reset mid-F_REQ drops the enables at once
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("ar_req_ren", 32'(rom_ren), 1);
    reset_n = 1'b0;
    #1;
    idle_outs("ar_req");
    step();
    reset_n = 1'b1;
    // asynchronous reset mid-F_HOLD clears the held instruction at once
    instr_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("ar_hold_vld_pre", 32'(instr_valid), 1);
    reset_n = 1'b0;
    #1;
    idle_outs("ar_hold");
    check("ar_hold_instr", 32'(instr), 0);
    step();
    reset_n = 1'b1;
    step();
    idle_outs("ar_hold_after");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
